// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED mode controller slice:
//   - mode_e      : 2-bit display mode encoding (FLOW, BOUNCE, BLINK, OFF)
//   - LED_W_DEF   : default number of LEDs driven
//   - PWM_W       : width of the brightness PWM counter (LED_PWM_EN builds)
//   - next_mode() : mode sequence applied on each press event
// -----------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    MODE_FLOW   = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  localparam int LED_W_DEF = 4;
  localparam int PWM_W     = 3;

  // FLOW -> BOUNCE -> BLINK -> OFF -> FLOW
  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      MODE_FLOW:   return MODE_BOUNCE;
      MODE_BOUNCE: return MODE_BLINK;
      MODE_BLINK:  return MODE_OFF;
      MODE_OFF:    return MODE_FLOW;
      default:     return MODE_FLOW;
    endcase
  endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl_if
// Board-side signal bundle of the LED mode controller.
//   key_n     : raw active-low push-button (asynchronous)
//   speed_sel : step period = TICK_CYCLES >> speed_sel
//   pause     : 1 = freeze step timer and pattern
//   led       : LED drive, 1 = on
//   mode      : current display mode
//   tick      : one-cycle pulse on each pattern step
//   duty      : PWM brightness (only when LED_PWM_EN is defined)
// Modports: master = board / stimulus side, slave = controller side.
// -----------------------------------------------------------------------------
interface led_mode_ctrl_if
  import led_pkg::*;
#(
  parameter int LED_W = LED_W_DEF
);

  logic             key_n;
  logic [1:0]       speed_sel;
  logic             pause;
  logic [LED_W-1:0] led;
  logic [1:0]       mode;
  logic             tick;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0] duty;
`endif

  modport master (
`ifdef LED_PWM_EN
    output duty,
`endif
    output key_n, speed_sel, pause,
    input  led, mode, tick
  );

  modport slave (
`ifdef LED_PWM_EN
    input  duty,
`endif
    input  key_n, speed_sel, pause,
    output led, mode, tick
  );

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Reusable push-button conditioner: 2-FF synchroniser, debouncer and press
// pulse for an active-low key.
//   sys_clk   : clock
//   sys_rst_n : asynchronous active-low reset (debounced state = released)
//   key_n     : raw active-low key, asynchronous to sys_clk
//   press     : one-cycle pulse on the debounced released->pressed transition
// The debounced level only follows the synchronised key after DEB_CYCLES
// consecutive samples that differ from it; any sample equal to the current
// level (a glitch) restarts the count.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter logic [31:0] DEB_CYCLES = 32'd1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic press
);

  // DEB_CYCLES of 0 behaves like 1 instead of underflowing the compare
  localparam logic [31:0] DEB_M1 = (DEB_CYCLES == 32'd0) ? 32'd0 : (DEB_CYCLES - 32'd1);

  logic [1:0]  sync_r;
  logic        deb_r;       // debounced level, active-low (1 = released)
  logic [31:0] cnt_r;
  logic        press_r;

  logic        deb_nxt_s;
  logic [31:0] cnt_nxt_s;
  logic        press_nxt_s;

  // Synchroniser chain; idles at released
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], key_n};
    end
  end

  // Stability counter and level acceptance
  always_comb begin
    deb_nxt_s   = deb_r;
    cnt_nxt_s   = 32'd0;
    press_nxt_s = 1'b0;
    if (sync_r[1] != deb_r) begin
      if (cnt_r >= DEB_M1) begin
        deb_nxt_s   = sync_r[1];
        cnt_nxt_s   = 32'd0;
        press_nxt_s = ~sync_r[1];
      end else begin
        cnt_nxt_s = cnt_r + 32'd1;
      end
    end else begin
      cnt_nxt_s = 32'd0;
    end
  end

  // Debounce state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      deb_r   <= 1'b1;
      cnt_r   <= 32'd0;
      press_r <= 1'b0;
    end else begin
      deb_r   <= deb_nxt_s;
      cnt_r   <= cnt_nxt_s;
      press_r <= press_nxt_s;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl
// Sequences a bank of LEDs through FLOW / BOUNCE / BLINK / OFF display modes.
// A debounced push-button steps the mode; a step timer with selectable speed
// and a pause input paces the pattern.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   io        : led_mode_ctrl_if.slave (key_n, speed_sel, pause in;
//               led, mode, tick out; duty in with LED_PWM_EN)
// Optional feature macro: LED_PWM_EN adds a duty input and a free-running
// PWM counter that gates led for brightness control.
// Outputs are all registered. tick is raised in the cycle right after the
// step edge, so led (registered from the pattern state) follows one cycle
// after tick.
// -----------------------------------------------------------------------------
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter logic [31:0] TICK_CYCLES = 32'd25_000_000,
  parameter logic [31:0] DEB_CYCLES  = 32'd1_000_000,
  parameter int          LED_W       = LED_W_DEF
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  led_mode_ctrl_if.slave io
);

  localparam int               POS_W    = $clog2(LED_W);
  localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(32'd1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(LED_W - 1);
  localparam logic [LED_W-1:0] LED_ONE  = LED_W'(32'd1);
  localparam logic [LED_W-1:0] LED_ALL  = {LED_W{1'b1}};
  localparam logic [LED_W-1:0] LED_NONE = {LED_W{1'b0}};
  localparam logic             DIR_UP   = 1'b1;
  localparam logic             DIR_DOWN = 1'b0;

  logic             press_s;

  mode_e            mode_r,  mode_nxt_s;
  logic [31:0]      count_r, count_nxt_s;
  logic [POS_W-1:0] pos_r,   pos_nxt_s;
  logic             dir_r,   dir_nxt_s;
  logic             phase_r, phase_nxt_s;  // BLINK: 1 = all on
  logic             tick_r,  tick_nxt_s;
  logic [LED_W-1:0] led_r,   led_nxt_s;

  logic [31:0]      period_s;
  logic [31:0]      period_m1_s;
  logic [LED_W-1:0] pattern_s;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_debounce (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_n     (io.key_n),
    .press     (press_s)
  );

  // Step period; a zero period (tiny TICK_CYCLES) steps every cycle
  always_comb begin
    period_s = TICK_CYCLES >> io.speed_sel;
    if (period_s == 32'd0) begin
      period_m1_s = 32'd0;
    end else begin
      period_m1_s = period_s - 32'd1;
    end
  end

  // Mode FSM next state, step timer and pattern-state advance.
  // A press outranks a coinciding step; >= lets a speed-up mid-count
  // step immediately instead of running the counter round.
  always_comb begin
    mode_nxt_s  = mode_r;
    count_nxt_s = count_r;
    pos_nxt_s   = pos_r;
    dir_nxt_s   = dir_r;
    phase_nxt_s = phase_r;
    tick_nxt_s  = 1'b0;
    if (press_s) begin
      mode_nxt_s  = next_mode(mode_r);
      count_nxt_s = 32'd0;
      pos_nxt_s   = POS_ZERO;
      dir_nxt_s   = DIR_UP;
      phase_nxt_s = 1'b1;
    end else if (io.pause) begin
      count_nxt_s = count_r;
    end else if (count_r >= period_m1_s) begin
      count_nxt_s = 32'd0;
      tick_nxt_s  = 1'b1;
      case (mode_r)
        MODE_FLOW: begin
          if (pos_r == POS_MAX) begin
            pos_nxt_s = POS_ZERO;
          end else begin
            pos_nxt_s = pos_r + POS_ONE;
          end
        end
        MODE_BOUNCE: begin
          // Reverse at the ends without dwelling on them
          if (dir_r == DIR_UP) begin
            if (pos_r == POS_MAX) begin
              dir_nxt_s = DIR_DOWN;
              pos_nxt_s = pos_r - POS_ONE;
            end else begin
              pos_nxt_s = pos_r + POS_ONE;
            end
          end else begin
            if (pos_r == POS_ZERO) begin
              dir_nxt_s = DIR_UP;
              pos_nxt_s = POS_ONE;
            end else begin
              pos_nxt_s = pos_r - POS_ONE;
            end
          end
        end
        MODE_BLINK: phase_nxt_s = ~phase_r;
        MODE_OFF:   pos_nxt_s   = pos_r;
        default:    pos_nxt_s   = POS_ZERO;
      endcase
    end else begin
      count_nxt_s = count_r + 32'd1;
    end
  end

  // Pattern decode from the current pattern state
  always_comb begin
    pattern_s = LED_NONE;
    case (mode_r)
      MODE_FLOW:   pattern_s = LED_ONE << pos_r;
      MODE_BOUNCE: pattern_s = LED_ONE << pos_r;
      MODE_BLINK:  pattern_s = phase_r ? LED_ALL : LED_NONE;
      MODE_OFF:    pattern_s = LED_NONE;
      default:     pattern_s = LED_NONE;
    endcase
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_r;

  // Free-running brightness counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt_r <= {PWM_W{1'b0}};
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_W'(1'b1);
    end
  end

  // Brightness gating: duty 7 keeps LEDs on every slot, duty 0 one slot in 8
  always_comb begin
    led_nxt_s = pattern_s & {LED_W{pwm_cnt_r <= io.duty}};
  end
`else
  // No brightness control: drive the pattern directly
  always_comb begin
    led_nxt_s = pattern_s;
  end
`endif

  // State and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_r  <= MODE_FLOW;
      count_r <= 32'd0;
      pos_r   <= POS_ZERO;
      dir_r   <= DIR_UP;
      phase_r <= 1'b1;
      tick_r  <= 1'b0;
      led_r   <= LED_NONE;
    end else begin
      mode_r  <= mode_nxt_s;
      count_r <= count_nxt_s;
      pos_r   <= pos_nxt_s;
      dir_r   <= dir_nxt_s;
      phase_r <= phase_nxt_s;
      tick_r  <= tick_nxt_s;
      led_r   <= led_nxt_s;
    end
  end

  assign io.led  = led_r;
  assign io.mode = mode_r;
  assign io.tick = tick_r;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_mode_ctrl
// Directed bench for led_mode_ctrl with TICK_CYCLES=8, DEB_CYCLES=4, LED_W=4.
// Expected (led, mode) pairs are queued as stimulus is issued; a monitor pops
// one entry each time the DUT's (led, mode) pair changes. Tick spacing and
// reset values are checked directly.
// -----------------------------------------------------------------------------
module tb_led_mode_ctrl;

  typedef struct packed {
    logic [3:0] led;
    logic [1:0] mode;
  } ev_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic mon_en = 1'b0;
  ev_t  last_ev;

  always #5 sys_clk = ~sys_clk;

  led_mode_ctrl_if #(.LED_W(4)) io ();

  led_mode_ctrl #(
    .TICK_CYCLES (32'd8),
    .DEB_CYCLES  (32'd4),
    .LED_W       (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .io        (io)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [3:0] l, input logic [1:0] m);
    ev_t e;
    e.led  = l;
    e.mode = m;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every change of (led, mode) must match the queue head
  always @(negedge sys_clk) begin : monitor
    ev_t cur;
    ev_t e;
    if (mon_en) begin
      cur.led  = io.led;
      cur.mode = io.mode;
      if (cur !== last_ev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got led=%b mode=%0d, required no change", cur.led, cur.mode);
        end else begin
          e = exp_q.pop_front();
          check("sb_led", 32'(cur.led), 32'(e.led));
          check("sb_mode", 32'(cur.mode), 32'(e.mode));
        end
        last_ev = cur;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Cycles until the next tick pulse, bounded
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (io.tick !== 1'b1 && n < 100);
    if (io.tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no tick in %0d cycles, required a tick", n);
    end
  endtask

  task automatic wait_state(input logic [3:0] l, input logic [1:0] m);
    int n;
    n = 0;
    while (!(io.led === l && io.mode === m) && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    if (!(io.led === l && io.mode === m)) begin
      checks++;
      errors++;
      $display("FAIL state_timeout: got led=%b mode=%0d, required led=%b mode=%0d", io.led, io.mode, l, m);
    end
  endtask

  task automatic wait_q_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic press(input int low_cycles);
    io.key_n = 1'b0;
    cyc(low_cycles);
    io.key_n = 1'b1;
    cyc(12);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  n;
    logic ok;
    io.key_n     = 1'b1;
    io.speed_sel = 2'd0;
    io.pause     = 1'b0;
`ifdef LED_PWM_EN
    io.duty      = 3'd7;
`endif
    sys_rst_n = 1'b0;
    cyc(3);
    check("rst_led", 32'(io.led), 32'h0);
    check("rst_mode", 32'(io.mode), 32'h0);
    check("rst_tick", 32'(io.tick), 32'h0);

    // FLOW after release
    last_ev.led  = 4'b0000;
    last_ev.mode = 2'd0;
    mon_en = 1'b1;
    expect_ev(4'b0001, 2'd0);
    sys_rst_n = 1'b1;
    cyc(1);
    check("led_after_release", 32'(io.led), 32'h1);
    expect_ev(4'b0010, 2'd0);
    expect_ev(4'b0100, 2'd0);
    wait_tick(n);
    wait_tick(n);
    check("tick_period_speed0", 32'(n), 32'd8);

    // Pause at led=0100 (one count already taken), then resume
    wait_state(4'b0100, 2'd0);
    io.pause = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge sys_clk);
      if (io.led !== 4'b0100 || io.tick !== 1'b0) ok = 1'b0;
    end
    check("pause_hold", 32'(ok), 32'd1);
    expect_ev(4'b1000, 2'd0);
    io.pause = 1'b0;
    wait_tick(n);
    check("resume_remaining", 32'(n), 32'd7);
    wait_state(4'b1000, 2'd0);
    io.pause = 1'b1;

    // Short glitch: no press event
    press(2);
    check("glitch_mode", 32'(io.mode), 32'd0);

    // Press into BOUNCE (paused), then run the bounce sequence
    expect_ev(4'b1000, 2'd1);
    expect_ev(4'b0001, 2'd1);
    press(6);
    check("press_mode_bounce", 32'(io.mode), 32'd1);
    expect_ev(4'b0010, 2'd1);
    expect_ev(4'b0100, 2'd1);
    expect_ev(4'b1000, 2'd1);
    expect_ev(4'b0100, 2'd1);
    expect_ev(4'b0010, 2'd1);
    expect_ev(4'b0001, 2'd1);
    io.pause = 1'b0;
    wait_state(4'b1000, 2'd1);
    wait_state(4'b0001, 2'd1);
    io.pause = 1'b1;
    wait_q_empty();

    // BLINK: starts all on, alternates
    expect_ev(4'b0001, 2'd2);
    expect_ev(4'b1111, 2'd2);
    press(6);
    expect_ev(4'b0000, 2'd2);
    expect_ev(4'b1111, 2'd2);
    io.pause = 1'b0;
    wait_state(4'b0000, 2'd2);
    wait_state(4'b1111, 2'd2);
    io.pause = 1'b1;
    wait_q_empty();

    // OFF: led dark, tick still runs; speed checks here
    expect_ev(4'b1111, 2'd3);
    expect_ev(4'b0000, 2'd3);
    press(6);
    wait_q_empty();
    check("press_mode_off", 32'(io.mode), 32'd3);
    io.pause = 1'b0;
    io.speed_sel = 2'd2;
    wait_tick(n);
    wait_tick(n);
    check("tick_period_speed2", 32'(n), 32'd2);
    io.speed_sel = 2'd0;
    wait_tick(n);
    wait_tick(n);
    check("tick_period_speed0_off", 32'(n), 32'd8);
    cyc(5);
    check("no_tick_at_count5", 32'(io.tick), 32'd0);
    io.speed_sel = 2'd3;
    cyc(1);
    check("tick_after_speedup", 32'(io.tick), 32'd1);
    cyc(3);
    check("tick_speed3", 32'(io.tick), 32'd1);

    // Wrap OFF -> FLOW -> BOUNCE, then reset mid-BOUNCE
    io.pause = 1'b1;
    io.speed_sel = 2'd0;
    expect_ev(4'b0000, 2'd0);
    expect_ev(4'b0001, 2'd0);
    press(6);
    expect_ev(4'b0001, 2'd1);
    press(6);
    wait_q_empty();
    expect_ev(4'b0010, 2'd1);
    expect_ev(4'b0100, 2'd1);
    io.pause = 1'b0;
    wait_state(4'b0100, 2'd1);
    expect_ev(4'b0000, 2'd0);
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(io.led), 32'h0);
    check("async_rst_mode", 32'(io.mode), 32'h0);
    check("async_rst_tick", 32'(io.tick), 32'h0);
    cyc(3);
    expect_ev(4'b0001, 2'd0);
    sys_rst_n = 1'b1;
    cyc(1);
    check("led_after_rerelease", 32'(io.led), 32'h1);
    cyc(2);
    wait_q_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
